// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge image loader.
// Build option: CART_IMAGE_CHECKSUM_EN adds the CHECK state.
package cart_pkg;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_FLAGS,
`ifdef CART_IMAGE_CHECKSUM_EN
        ST_CHECK,
`endif
        ST_SETTLE,
        ST_READY,
        ST_ERROR
    } cart_state_t;

    localparam int FLAGS_MAPPER_LSB = 0;
    localparam int FLAGS_MAPPER_MSB = 7;
    localparam logic [7:0] MAPPER_NROM  = 8'd0;
    localparam logic [7:0] MAPPER_UNROM = 8'd2;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/cart_lane_mux.sv
// Host byte-lane front end: write mask/replication and 2-deep pipelined read lane select.
module cart_lane_mux
    import cart_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [1:0]  lane,
    input  logic        wren,
    input  logic        rden,
    input  logic [7:0]  write_data,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  wen_mask,
    output logic [31:0] wdata,
    output logic [7:0]  read_data
);

    logic [1:0] sel_q1, sel_q2;
    logic       rd_q1, rd_q2;

    assign wen_mask = (enable && wren) ? lane_mask(lane) : 4'b0000;
    assign wdata    = {4{write_data}};

    // Select travels alongside the registered RAM address and the SPRAM read stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            sel_q1 <= 2'd0;
            sel_q2 <= 2'd0;
            rd_q1  <= 1'b0;
            rd_q2  <= 1'b0;
        end else begin
            sel_q1 <= lane;
            sel_q2 <= sel_q1;
            rd_q1  <= rden && enable;
            rd_q2  <= rd_q1;
        end
    end

    always_comb begin
        read_data = 8'h00;
        if (enable && rd_q2) begin
            unique case (sel_q2)
                2'd0: read_data = mem_rdata[7:0];
                2'd1: read_data = mem_rdata[15:8];
                2'd2: read_data = mem_rdata[23:16];
                default: read_data = mem_rdata[31:24];
            endcase
        end
    end

endmodule

// File: rtl/cart_image_loader.sv
// Cartridge image loader: streams a flash slot into word RAM, then serves host byte access.
// Build option: CART_IMAGE_CHECKSUM_EN verifies a sum word stored after the flags word.
//
//  state  | meaning
//  LOAD   | fetching image words, writing each to RAM
//  FLAGS  | fetching the mapper flags word
//  CHECK  | fetching and comparing the checksum word (checksum builds only)
//  SETTLE | waiting SETTLE_CYCLES before cart_ready
//  READY  | image valid, host byte access enabled
//  ERROR  | flash timeout or checksum mismatch; left only by reset or reload
module cart_image_loader
    import cart_pkg::*;
#(
    parameter int          IMAGE_WORDS   = 32768,
    parameter int          MEM_AW        = 15,
    parameter int          INDEX_W       = 4,
    parameter logic [23:0] FLASH_BASE    = 24'h100000,
    parameter int          SLOT_SHIFT    = 18,
    parameter int          SETTLE_CYCLES = 256,
    parameter int          TIMEOUT       = 4095
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              reload,
    input  logic [INDEX_W-1:0] index,
    output logic              cart_ready,
    output logic              load_error,
    output logic [31:0]       flags_out,
    input  logic [MEM_AW+1:0] address,
    input  logic              rden,
    input  logic              wren,
    input  logic [7:0]        write_data,
    output logic [7:0]        read_data,
    output logic              fm_valid,
    output logic [23:0]       fm_addr,
    input  logic              fm_ready,
    input  logic [31:0]       fm_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [3:0]        mem_wen,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int PTR_W = $clog2(IMAGE_WORDS + 3);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYCLES - 1);

    cart_state_t          state_q, state_d;
    logic [PTR_W-1:0]     ptr_q;
    logic [INDEX_W-1:0]   idx_q;
    logic [31:0]          flags_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [SET_W-1:0]     settle_q;
    logic [MEM_AW-1:0]    mem_addr_q;
    logic [3:0]           mem_wen_q;
    logic [31:0]          mem_wdata_q;
    logic [3:0]           host_wen;
    logic [31:0]          host_wdata;
    logic                 waiting, is_ready;
`ifdef CART_IMAGE_CHECKSUM_EN
    logic [31:0]          sum_q;
`endif

`ifdef CART_IMAGE_CHECKSUM_EN
    assign waiting = (state_q == ST_LOAD) || (state_q == ST_FLAGS) || (state_q == ST_CHECK);
`else
    assign waiting = (state_q == ST_LOAD) || (state_q == ST_FLAGS);
`endif
    assign is_ready   = (state_q == ST_READY);
    assign cart_ready = is_ready;
    assign load_error = (state_q == ST_ERROR);
    assign flags_out  = flags_q;
    assign fm_valid   = waiting && !reset;
    assign fm_addr    = FLASH_BASE + (24'(idx_q) << SLOT_SHIFT) + 24'({ptr_q, 2'b00});
    assign mem_addr   = mem_addr_q;
    assign mem_wen    = mem_wen_q;
    assign mem_wdata  = mem_wdata_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: begin
                if (fm_ready) begin
                    if (ptr_q == PTR_W'(IMAGE_WORDS - 1)) state_d = ST_FLAGS;
                end else if (tmo_q == '0) begin
                    state_d = ST_ERROR;
                end
            end
            ST_FLAGS: begin
                if (fm_ready) begin
`ifdef CART_IMAGE_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_SETTLE;
`endif
                end else if (tmo_q == '0) begin
                    state_d = ST_ERROR;
                end
            end
`ifdef CART_IMAGE_CHECKSUM_EN
            ST_CHECK: begin
                if (fm_ready) state_d = (fm_rdata == sum_q) ? ST_SETTLE : ST_ERROR;
                else if (tmo_q == '0) state_d = ST_ERROR;
            end
`endif
            ST_SETTLE: if (settle_q == '0) state_d = ST_READY;
            ST_READY:  state_d = ST_READY;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_LOAD;
        endcase
        if (reload) state_d = ST_LOAD;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            ptr_q    <= '0;
            idx_q    <= index;
            flags_q  <= '0;
            tmo_q    <= TMO_LOAD;
            settle_q <= SET_LOAD;
`ifdef CART_IMAGE_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (reload) begin
                ptr_q   <= '0;
                idx_q   <= index;
                flags_q <= '0;
`ifdef CART_IMAGE_CHECKSUM_EN
                sum_q   <= '0;
`endif
            end else begin
                if (waiting && fm_ready) ptr_q <= ptr_q + 1'b1;
                if (state_q == ST_FLAGS && fm_ready) flags_q <= fm_rdata;
`ifdef CART_IMAGE_CHECKSUM_EN
                if (state_q == ST_LOAD && fm_ready) sum_q <= sum_q + fm_rdata;
`endif
            end
            // Timeout restarts on every accepted word, so it bounds the wait for one word.
            tmo_q    <= (!waiting || fm_ready || reload) ? TMO_LOAD : tmo_q - 1'b1;
            settle_q <= (state_q == ST_SETTLE && !reload) ? settle_q - 1'b1 : SET_LOAD;
        end
    end

    // Single registered RAM port shared by the loader and the host.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_addr_q  <= '0;
            mem_wen_q   <= 4'b0000;
            mem_wdata_q <= '0;
        end else begin
            mem_wen_q <= 4'b0000;
            if (!reload) begin
                if (state_q == ST_LOAD) begin
                    mem_addr_q  <= MEM_AW'(ptr_q);
                    mem_wdata_q <= fm_rdata;
                    if (fm_ready) mem_wen_q <= 4'b1111;
                end else if (is_ready) begin
                    mem_addr_q  <= address[MEM_AW+1:2];
                    mem_wdata_q <= host_wdata;
                    mem_wen_q   <= host_wen;
                end
            end
        end
    end

    cart_lane_mux u_lane_mux (
        .clock      (clock),
        .reset      (reset),
        .enable     (is_ready),
        .lane       (address[1:0]),
        .wren       (wren),
        .rden       (rden),
        .write_data (write_data),
        .mem_rdata  (mem_rdata),
        .wen_mask   (host_wen),
        .wdata      (host_wdata),
        .read_data  (read_data)
    );

endmodule

// File: tb/tb_cart_image_loader.sv
// Self-checking bench for cart_image_loader with flash, SPRAM and host byte-image models.
module tb_cart_image_loader;

    localparam int          IW   = 16;
    localparam int          AW   = 4;
    localparam int          XW   = 4;
    localparam int          SS   = 18;
    localparam int          SC   = 4;
    localparam int          TO   = 20;
    localparam logic [23:0] BASE = 24'h100000;

    logic          clock, reset, reload;
    logic [XW-1:0] index;
    logic          cart_ready, load_error;
    logic [31:0]   flags_out;
    logic [AW+1:0] address;
    logic          rden, wren;
    logic [7:0]    write_data, read_data;
    logic          fm_valid, fm_ready;
    logic [23:0]   fm_addr;
    logic [31:0]   fm_rdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_wen;
    logic [31:0]   mem_wdata, mem_rdata;

    cart_image_loader #(
        .IMAGE_WORDS(IW), .MEM_AW(AW), .INDEX_W(XW), .FLASH_BASE(BASE),
        .SLOT_SHIFT(SS), .SETTLE_CYCLES(SC), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .reload(reload), .index(index),
        .cart_ready(cart_ready), .load_error(load_error), .flags_out(flags_out),
        .address(address), .rden(rden), .wren(wren), .write_data(write_data),
        .read_data(read_data), .fm_valid(fm_valid), .fm_addr(fm_addr),
        .fm_ready(fm_ready), .fm_rdata(fm_rdata), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          vectors = 0, miscompares = 0;
    logic [31:0] ram [0:(1<<AW)-1];
    int          wr_cnt = 0;
    logic [7:0]  img [0:4*IW-1];
    logic [31:0] ck_sum;
    bit          bad_ck = 0, stall = 0;
    int          exp_ptr = 0, ph = 0;
    logic [XW-1:0] cur_idx;

    // SPRAM: synchronous read-first, byte write enables.
    always @(posedge clock) begin
        logic [31:0] rd;
        rd = ram[mem_addr];
        for (int b = 0; b < 4; b++)
            if (mem_wen[b]) ram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        if (mem_wen == 4'hF) wr_cnt++;
        mem_rdata <= rd;
    end

    function automatic logic [31:0] fword(input int i);
        if (i == IW + 1) return ck_sum ^ {31'd0, bad_ck};
        return 32'hA500_0000 | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of flash responder: ready on every third requesting cycle.
    task automatic cyc(input int rl_at);
        @(negedge clock);
        reload = 0; rden = 0; wren = 0; fm_ready = 0;
        if (fm_valid && !stall) begin
            ph++;
            fm_ready = (ph % 3 == 0);
        end
        fm_rdata = fword(int'(fm_addr[SS-1:2]));
        if (fm_ready) begin
            chk("fm_addr", 32'(fm_addr), 32'(BASE + (24'(cur_idx) << SS) + 24'(exp_ptr * 4)));
            if (exp_ptr == rl_at) begin
                reload = 1; cur_idx = index; exp_ptr = 0;
            end else exp_ptr++;
        end
    endtask

    task automatic do_reload(input logic [XW-1:0] idx);
        index = idx; reload = 1; fm_ready = 0; cur_idx = idx; exp_ptr = 0;
    endtask

    task automatic run_load(input int budget, output int t_flags, output int t_ready);
        t_flags = -1; t_ready = -1;
        for (int n = 0; n < budget; n++) begin
            cyc(-1);
            if (t_flags < 0 && flags_out != 0) t_flags = n;
            if (cart_ready) begin t_ready = n; break; end
        end
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < IW; i++) chk(tag, ram[i], 32'hA500_0000 | 32'(i));
        for (int a = 0; a < 4*IW; a++) img[a] = 8'((32'hA500_0000 | 32'(a / 4)) >> (8 * (a % 4)));
    endtask

    int tf, tr, n, e, a, op;
    int pend[$];

    initial begin
        reset = 1; reload = 0; index = 2; cur_idx = 2; address = '0;
        rden = 0; wren = 0; write_data = 0; fm_ready = 0; fm_rdata = 0;
        ck_sum = 0;
        for (int i = 0; i < IW; i++) ck_sum += 32'hA500_0000 | 32'(i);
        for (int i = 0; i < (1<<AW); i++) ram[i] = 0;

        // 1: reset values, first request and full load of slot 2
        repeat (3) @(negedge clock);
        chk("rst_fm_valid", 32'(fm_valid), 0);
        chk("rst_cart_ready", 32'(cart_ready), 0);
        chk("rst_load_error", 32'(load_error), 0);
        chk("rst_flags", flags_out, 0);
        chk("rst_mem_wen", 32'(mem_wen), 0);
        chk("rst_read_data", 32'(read_data), 0);
        wr_cnt = 0;
        reset = 0;
        @(negedge clock);
        chk("first_fm_valid", 32'(fm_valid), 1);
        chk("first_fm_addr", 32'(fm_addr), 32'h0018_0000);
        run_load(300, tf, tr);
        chk("load1_ready", 32'(tr >= 0), 1);
        chk("load1_flags", flags_out, 32'hA500_0010);
`ifndef CART_IMAGE_CHECKSUM_EN
        chk("settle_cycles", 32'(tr - tf), 32'(SC));
`endif
        chk("load1_writes", 32'(wr_cnt), 32'(IW));
        chk("load1_error", 32'(load_error), 0);
        check_image("load1_ram");

        // 2: byte reads, 2-cycle latency
        cyc(-1); address = 5; rden = 1;
        cyc(-1); cyc(-1);
        chk("read_addr5", 32'(read_data), 32'h00);
        address = 7; rden = 1;
        cyc(-1); cyc(-1);
        chk("read_addr7", 32'(read_data), 32'hA5);

        // 3: byte write lane mask and replication, then read-back
        cyc(-1); address = 6; write_data = 8'h3C; wren = 1;
        cyc(-1);
        chk("wr_mem_wen", 32'(mem_wen), 32'b0100);
        chk("wr_mem_wdata", mem_wdata, 32'h3C3C_3C3C);
        chk("wr_mem_addr", 32'(mem_addr), 1);
        img[6] = 8'h3C;
        address = 6; rden = 1;
        cyc(-1); cyc(-1);
        chk("readback_addr6", 32'(read_data), 32'h3C);

        // random host traffic against the byte-image model
        pend.delete();
        for (int k = 0; k < 60; k++) begin
            cyc(-1);
            if (pend.size() == 2) begin
                e = pend.pop_front();
                if (e >= 0) chk("rand_read", 32'(read_data), 32'(e));
            end
            op = $urandom_range(0, 2);
            a = $urandom_range(0, 4*IW - 1);
            address = 6'(a);
            if (op == 0) begin
                rden = 1; pend.push_back(int'(img[a]));
            end else if (op == 1) begin
                wren = 1; write_data = 8'($urandom); img[a] = write_data; pend.push_back(-1);
            end else pend.push_back(-1);
        end
        repeat (2) begin
            cyc(-1);
            e = pend.pop_front();
            if (e >= 0) chk("rand_read", 32'(read_data), 32'(e));
        end

        // 4: flash stall at ptr 7 -> timeout error, then reload slot 1
        cyc(-1); do_reload(2);
        for (int k = 0; k < 100; k++) begin cyc(-1); if (exp_ptr == 7) break; end
        stall = 1;
        for (n = 1; n < 60; n++) begin cyc(-1); if (load_error) break; end
        chk("timeout_cycles", 32'(n - 1), 32'(TO));
        chk("err_load_error", 32'(load_error), 1);
        chk("err_fm_valid", 32'(fm_valid), 0);
        chk("err_cart_ready", 32'(cart_ready), 0);
        address = 2; wren = 1; write_data = 8'hEE; rden = 1;
        cyc(-1);
        chk("err_no_write", 32'(mem_wen), 0);
        cyc(-1);
        chk("err_read_zero", 32'(read_data), 0);
        stall = 0; do_reload(1);
        cyc(-1);
        chk("reload_fm_addr", 32'(fm_addr), 32'h0014_0000);
        chk("reload_clears_err", 32'(load_error), 0);
        run_load(300, tf, tr);
        chk("load2_ready", 32'(tr >= 0), 1);
        check_image("load2_ram");

        // 5: reload coincident with the fm_ready for word 9
        for (int i = 0; i < (1<<AW); i++) ram[i] = 0;
        wr_cnt = 0;
        do_reload(1);
        for (int k = 0; k < 100; k++) begin cyc(9); if (reload) break; end
        cyc(-1); cyc(-1);
        chk("rl_writes", 32'(wr_cnt), 9);
        chk("rl_word9", ram[9], 0);
        chk("rl_flags_zero", flags_out, 0);
        chk("rl_not_ready", 32'(cart_ready), 0);
        run_load(300, tf, tr);
        chk("load3_ready", 32'(tr >= 0), 1);
        chk("load3_flags", flags_out, 32'hA500_0010);
        check_image("load3_ram");

`ifdef CART_IMAGE_CHECKSUM_EN
        // 6: corrupted checksum word -> error, never ready
        bad_ck = 1; do_reload(1);
        for (n = 0; n < 300; n++) begin cyc(-1); if (load_error || cart_ready) break; end
        chk("ck_bad_error", 32'(load_error), 1);
        chk("ck_bad_ready", 32'(cart_ready), 0);
        bad_ck = 0; do_reload(1);
        run_load(300, tf, tr);
        chk("ck_good_ready", 32'(tr >= 0), 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
